xor_tree_mux_pipe: RTL and testbench

Pipelined, parametrised XOR-reduction (parity) engine whose only logic primitive is the 2:1 `mux`; every XOR node is a `mux`-built cell. It accepts a `WIDTH`-bit word per cycle over a valid/ready handshake. It emits the word's parity together with the original word after one register stage per tree level. It is the successor to the single two-input `mux`-based XOR gate and serves as the parity/checksum building block for later datapath exercises.

---
 rtl/xor_tree_pkg.sv | 17 +
 rtl/mux.sv | 11 +
 rtl/xor_cell_mux.sv | 13 +
 rtl/xor_tree_mux_pipe.sv | 101 ++++++++++
 tb/tb_xor_tree_mux_pipe.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_tree_pkg.sv
// Shared sizing helpers for the mux-built XOR reduction tree.
package xor_tree_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int MIN_WIDTH = 2;

  function automatic int levels(int w);
    return $clog2(w);
  endfunction

  // Node count at tree level k; an odd leftover node still occupies a slot.
  function automatic int nodes(int w, int k);
    if (k <= 0) return w;
    return (nodes(w, k - 1) + 1) / 2;
  endfunction

endpackage

// File: rtl/mux.sv
// 2:1 multiplexer, the only logic primitive of the parity tree.
module mux (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/xor_cell_mux.sv
// Two-input XOR node built from an inverter mux feeding a select mux.
module xor_cell_mux (
  input  logic a,
  input  logic b,
  output logic o
);

  logic w_na;

  mux u_inv (.sel(a), .d0(1'b1), .d1(1'b0), .y(w_na));
  mux u_sel (.sel(b), .d0(a),    .d1(w_na), .y(o));

endmodule

// File: rtl/xor_tree_mux_pipe.sv
// Pipelined XOR-reduction tree, one register stage per level, valid/ready flow.
// Define XOR_TREE_INVERT_EN to report even parity instead of odd parity.
module xor_tree_mux_pipe
  import xor_tree_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             down_parity,
  output logic [WIDTH-1:0] down_data
);

  localparam int L = levels(WIDTH);

  logic [L:1]            r_valid;
  logic [L:1][WIDTH-1:0] r_part;
  logic [L:1][WIDTH-1:0] r_word;

  logic [L+1:1]          w_ready;
  logic [L:0]            w_vsrc;
  logic [L:0][WIDTH-1:0] w_psrc;
  logic [L:0][WIDTH-1:0] w_wsrc;
  logic [L:1][WIDTH-1:0] w_node;
  logic [L:1][WIDTH-1:0] w_load;
  logic                  w_root;
  logic                  w_unused;

  // Index 0 is the upstream port, index k the output of stage k.
  assign w_vsrc = {r_valid, up_valid};
  assign w_psrc = {r_part, up_data};
  assign w_wsrc = {r_word, up_data};

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int NP = nodes(WIDTH, k - 1);
    localparam int NK = nodes(WIDTH, k);

    for (genvar j = 0; j < NK; j++) begin : g_node
      logic w_b;
      if (2 * j + 1 < NP) begin : g_pair
        assign w_b = w_psrc[k-1][2*j+1];
      end else begin : g_pad
        assign w_b = 1'b0;
      end
      xor_cell_mux u_cell (.a(w_psrc[k-1][2*j]), .b(w_b), .o(w_node[k][j]));
    end

    assign w_node[k][WIDTH-1:NK] = '0;

    if (k == L) begin : g_root
      assign w_load[k] = {w_node[k][WIDTH-1:1], w_root};
    end else begin : g_inner
      assign w_load[k] = w_node[k];
    end
  end

`ifdef XOR_TREE_INVERT_EN
  mux u_root_inv (.sel(w_node[L][0]), .d0(1'b1), .d1(1'b0), .y(w_root));
`else
  assign w_root = w_node[L][0];
`endif

  // A stage can take new data when empty or when its successor drains it.
  always_comb begin
    w_ready        = '0;
    w_ready[L+1]   = down_ready;
    for (int unsigned i = 0; i < L; i++) begin
      w_ready[L-i] = !r_valid[L-i] || w_ready[L-i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_part  <= '0;
      r_word  <= '0;
    end else begin
      for (int unsigned k = 1; k <= L; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_vsrc[k-1];
          r_part[k]  <= w_load[k];
          r_word[k]  <= w_wsrc[k-1];
        end
      end
    end
  end

  assign up_ready    = w_ready[1];
  assign down_valid  = r_valid[L];
  assign down_parity = r_part[L][0];
  assign down_data   = r_word[L];

  // Padding bits and the last stage's upper partials never feed another node.
  assign w_unused = &{1'b0, w_psrc, w_wsrc, w_vsrc};

endmodule

// File: tb/tb_xor_tree_mux_pipe.sv
// Self-checking bench for xor_tree_mux_pipe at WIDTH 8, 5 and 2 (honours XOR_TREE_INVERT_EN).
module tb_xor_tree_mux_pipe;

`ifdef XOR_TREE_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic       uv8, ur8, dv8, dr8, dp8;
  logic [7:0] ud8, dd8;
  logic       uv5, ur5, dv5, dr5, dp5;
  logic [4:0] ud5, dd5;
  logic       uv2, ur2, dv2, dr2, dp2;
  logic [1:0] ud2, dd2;

  int total = 0;
  int bad   = 0;
  int acc8 = 0, ret8 = 0, acc5 = 0, acc2 = 0;

  logic [7:0] q8[$];
  logic [4:0] q5[$];
  logic [1:0] q2[$];

  typedef struct {
    logic [7:0] data;
    bit         odd;
  } vec_t;

  always #5 clk = ~clk;

  xor_tree_mux_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(uv8), .up_ready(ur8), .up_data(ud8),
    .down_valid(dv8), .down_ready(dr8), .down_parity(dp8), .down_data(dd8)
  );

  xor_tree_mux_pipe #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(uv5), .up_ready(ur5), .up_data(ud5),
    .down_valid(dv5), .down_ready(dr5), .down_parity(dp5), .down_data(dd5)
  );

  xor_tree_mux_pipe #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(uv2), .up_ready(ur2), .up_data(ud2),
    .down_valid(dv2), .down_ready(dr2), .down_parity(dp2), .down_data(dd2)
  );

  // Reference parity: count the ones, odd count -> 1, optionally inverted.
  function automatic logic epar(input logic [63:0] d);
    return (($countones(d) % 2) == 1) != INV;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic spurious(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got an output word expected none", nm);
  endtask

  // Called at edge+1 with inputs set; scores handshakes, advances one clock.
  task automatic tick();
    logic [63:0] e;
    #1;
    if (dv8 && dr8) begin
      ret8++;
      if (q8.size() == 0) spurious("w8_out");
      else begin
        e = 64'(q8.pop_front());
        chk("w8_parity", 64'(dp8), 64'(epar(e)));
        chk("w8_data", 64'(dd8), e);
      end
    end
    if (uv8 && ur8) begin q8.push_back(ud8); acc8++; end
    if (dv5 && dr5) begin
      if (q5.size() == 0) spurious("w5_out");
      else begin
        e = 64'(q5.pop_front());
        chk("w5_parity", 64'(dp5), 64'(epar(e)));
        chk("w5_data", 64'(dd5), e);
      end
    end
    if (uv5 && ur5) begin q5.push_back(ud5); acc5++; end
    if (dv2 && dr2) begin
      if (q2.size() == 0) spurious("w2_out");
      else begin
        e = 64'(q2.pop_front());
        chk("w2_parity", 64'(dp2), 64'(epar(e)));
        chk("w2_data", 64'(dd2), e);
      end
    end
    if (uv2 && ur2) begin q2.push_back(ud2); acc2++; end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[8];
    logic [7:0] bbw[4];
    bit         bbp[4];
    int         base, obase;

    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h01, 1'b1};
    tbl[2] = '{8'h03, 1'b0};
    tbl[3] = '{8'h07, 1'b1};
    tbl[4] = '{8'hFF, 1'b0};
    tbl[5] = '{8'h00, 1'b0};
    tbl[6] = '{8'h80, 1'b1};
    tbl[7] = '{8'h7F, 1'b1};
    bbw[0] = 8'h01; bbw[1] = 8'h03; bbw[2] = 8'h07; bbw[3] = 8'hFF;
    bbp[0] = 1'b1;  bbp[1] = 1'b0;  bbp[2] = 1'b1;  bbp[3] = 1'b0;

    rst_n = 1'b0;
    uv8 = 1'b0; ud8 = '0; dr8 = 1'b1;
    uv5 = 1'b0; ud5 = '0; dr5 = 1'b1;
    uv2 = 1'b0; ud2 = '0; dr2 = 1'b1;

    #12;
    chk("rst_down_valid", 64'(dv8), 0);
    chk("rst_down_parity", 64'(dp8), 0);
    chk("rst_down_data", 64'(dd8), 0);
    chk("rst_up_ready", 64'(ur8), 1);
    chk("rst_up_ready_w5", 64'(ur5), 1);
    chk("rst_up_ready_w2", 64'(ur2), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single words: down_valid exactly three cycles after presentation.
    for (int i = 0; i < 8; i++) begin
      uv8 = 1'b1;
      ud8 = tbl[i].data;
      tick();
      uv8 = 1'b0;
      chk("single_valid_c1", 64'(dv8), 0);
      tick();
      chk("single_valid_c2", 64'(dv8), 0);
      tick();
      chk("single_valid_c3", 64'(dv8), 1);
      chk("single_parity", 64'(dp8), 64'(tbl[i].odd != INV));
      chk("single_data", 64'(dd8), 64'(tbl[i].data));
    end
    tick();
    chk("single_drained", 64'(dv8), 0);

    // Back-to-back words appear on consecutive cycles 3..6.
    for (int t = 1; t <= 7; t++) begin
      uv8 = (t <= 4);
      if (t <= 4) ud8 = bbw[t-1];
      tick();
      if (t >= 3 && t <= 6) begin
        chk("b2b_valid", 64'(dv8), 1);
        chk("b2b_parity", 64'(dp8), 64'(bbp[t-3] != INV));
      end else begin
        chk("b2b_idle", 64'(dv8), 0);
      end
    end
    uv8 = 1'b0;
    tick();

    // Backpressure: three words buffered, then up_ready low; release keeps order.
    dr8 = 1'b0;
    base = acc8;
    obase = ret8;
    for (int c = 0; c < 6; c++) begin
      uv8 = 1'b1;
      ud8 = 8'(acc8 - base + 1);
      tick();
    end
    chk("bp_accepted", 64'(acc8 - base), 3);
    chk("bp_up_ready_low", 64'(ur8), 0);
    chk("bp_down_valid", 64'(dv8), 1);
    dr8 = 1'b1;
    #1;
    chk("bp_full_simul_up_ready", 64'(ur8), 1);
    for (int c = 0; c < 20 && (ret8 - obase) < 6; c++) begin
      uv8 = (acc8 - base < 6);
      ud8 = 8'(acc8 - base + 1);
      tick();
    end
    uv8 = 1'b0;
    chk("bp_retired", 64'(ret8 - obase), 6);
    chk("bp_queue_empty", 64'(q8.size()), 0);

    // Odd padding (WIDTH=5) and the single-level tree (WIDTH=2).
    uv5 = 1'b1; ud5 = 5'b10101;
    uv2 = 1'b1; ud2 = 2'b11;
    tick();
    uv5 = 1'b0;
    uv2 = 1'b0;
    chk("w2_valid_c1", 64'(dv2), 1);
    chk("w2_parity_c1", 64'(dp2), 64'(1'b0 != INV));
    chk("w2_data_c1", 64'(dd2), 64'(2'b11));
    chk("w5_valid_c1", 64'(dv5), 0);
    tick();
    chk("w2_valid_c2", 64'(dv2), 0);
    chk("w5_valid_c2", 64'(dv5), 0);
    tick();
    chk("w5_valid_c3", 64'(dv5), 1);
    chk("w5_parity_c3", 64'(dp5), 64'(1'b1 != INV));
    chk("w5_data_c3", 64'(dd5), 64'(5'b10101));
    tick();

    // Reset with three words in flight discards them all.
    for (int c = 0; c < 3; c++) begin
      uv8 = 1'b1;
      ud8 = 8'($urandom);
      tick();
    end
    uv8 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_down_valid", 64'(dv8), 0);
    chk("midrst_down_parity", 64'(dp8), 0);
    chk("midrst_down_data", 64'(dd8), 0);
    chk("midrst_up_ready", 64'(ur8), 1);
    q8.delete();
    q5.delete();
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("midrst_no_stale", 64'(dv8), 0);
    end

    // Random traffic with random backpressure on all three widths.
    base = acc8;
    for (int c = 0; c < 20000 && (acc8 - base) < 1000; c++) begin
      uv8 = (acc8 - base < 1000) && ($urandom_range(0, 3) != 0);
      ud8 = 8'($urandom);
      dr8 = ($urandom_range(0, 3) != 0);
      uv5 = ($urandom_range(0, 1) != 0);
      ud5 = 5'($urandom);
      dr5 = ($urandom_range(0, 2) != 0);
      uv2 = ($urandom_range(0, 2) != 0);
      ud2 = 2'($urandom);
      dr2 = ($urandom_range(0, 1) != 0);
      tick();
    end
    chk("rnd_accepted", 64'(acc8 - base), 1000);
    uv8 = 1'b0; uv5 = 1'b0; uv2 = 1'b0;
    dr8 = 1'b1; dr5 = 1'b1; dr2 = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("rnd_drained_w8", 64'(q8.size()), 0);
    chk("rnd_drained_w5", 64'(q5.size()), 0);
    chk("rnd_drained_w2", 64'(q2.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
